id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Pipeline stage directly downstream of the register file. It captures the two read-port values (Port A / Port B) for the instruction in decode.
- It resolves operands: EX forwarding, then WB forwarding, then register-file value, with an ARM r15 (PC) special case.
- It presents a registered operand bundle to the execute stage over a valid/ready handshake.
- A one-entry skid buffer keeps in_ready registered, so there is no combinational ready path from execute back to decode.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle passed through unchanged.
- PC_OFFSET, 8, constant added to in_pc when an operand address is 4'hF (ARM pipeline PC read).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Clr  in  1  synchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; registered (equals ~skid_valid).
- in_rn  in  4  address driven on register-file sel1 (operand A source).
- in_rm  in  4  address driven on register-file sel2 (operand B source).
- in_rd  in  4  destination register.
- in_wb  in  1  instruction writes in_rd.
- in_ctrl  in  CTRL_W  decoded control, pass-through.
- in_pc  in  32  address of the instruction.
- rf_a  in  32  register-file Port A (value of in_rn).
- rf_b  in  32  register-file Port B (value of in_rm).
- ex_fwd_en  in  1  EX stage result is valid for forwarding.
- ex_fwd_rd  in  4  EX destination.
- ex_fwd_data  in  32  EX result.
- wb_fwd_en  in  1  WB stage writing this cycle.
- wb_fwd_rd  in  4  WB destination.
- wb_fwd_data  in  32  WB data.
- flush  in  1  branch or exception kill.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts.
- out_a  out  32  resolved operand A.
- out_b  out  32  resolved operand B.
- out_rd  out  4  destination register.
- out_wb  out  1  write-back enable.
- out_ctrl  out  CTRL_W  control pass-through.

Behaviour:
- Reset (Clr=0 at posedge):
  - out_valid, skid_valid cleared to 0.
  - out_a, out_b, out_rd, out_wb, out_ctrl cleared to 0.
  - Skid contents cleared to 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset overrides flush and all handshakes.
- Operand resolution is combinational and applied at capture time. Per operand, with addr = in_rn (A) or in_rm (B), first match wins:
  1. addr==4'hF gives in_pc + PC_OFFSET (mod 2^32). r15 is never forwarded.
  2. ex_fwd_en && ex_fwd_rd==addr gives ex_fwd_data.
  3. wb_fwd_en && wb_fwd_rd==addr gives wb_fwd_data.
  4. Otherwise rf_a / rf_b.
- Accept: in_valid && in_ready. Output advance: out_valid && out_ready.
- Registers: output register (OUT) and skid register (SKID). State pair (out_valid, skid_valid):
  - EMPTY (0,0): accept loads OUT, giving FULL1.
  - FULL1 (1,0):
    - Accept with advance: OUT reloads from the input, stays FULL1.
    - Advance only: goes to EMPTY.
    - Accept without advance: captures into SKID, giving FULL2.
  - FULL2 (1,1): in_ready=0.
    - Advance: OUT loads from SKID, SKID cleared, giving FULL1.
    - No advance: hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 per cycle while out_ready=1.
- Data is held stable while out_valid && !out_ready.
- Forwarding is resolved only at capture. Values held in SKID/OUT are not re-forwarded. Decode's hazard unit must stall on any dependency that resolution at capture cannot satisfy.
- Flush at posedge:
  - out_valid and skid_valid go to 0.
  - An accept in the same cycle is dropped.
  - in_ready is 1 next cycle.
  - Data registers need not clear.
- Simultaneous EX and WB hit on the same register: EX wins.
- Both operands may address the same register and resolve identically.

Decomposition:
- Shared package holds:
  - REG_PC = 4'hF and PC_OFFSET default.
  - CTRL_W.
  - The operand-bundle typedef {a, b, rd, wb, ctrl}, reused by the EX stage.
- One sub-module, operand_fwd_mux: a combinational 4-way priority selector instantiated twice (A and B).
- State and registers stay in the top module.

Test Plan:
- Reset: Clr=0 for 2 cycles mid-traffic -> out_valid=0, out_a=0, in_ready=1 after release; a bundle accepted in the reset cycle is discarded.
- Plain capture: in_rn=3, rf_a=32'h0000B0B0, no forwarding, out_ready=1 -> out_a=32'h0000B0B0 one cycle later; then in_rm=4'hF, in_pc=32'h00001000 -> out_b=32'h00001008.
- Forward priority: in_rn=5, ex_fwd rd=5 data=32'hAAAA0000, wb_fwd rd=5 data=32'h0000BBBB -> out_a=32'hAAAA0000; drop ex_fwd_en -> 32'h0000BBBB; in_rn=15 with ex_fwd rd=15 -> in_pc+8.
- Backpressure: stream 4 bundles with out_ready=0 -> first two held (FULL2), in_ready=0 after the second accept; raise out_ready -> bundles emerge in order, none lost or duplicated.
- Flush in FULL2 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed and incoming bundles never appear.
- Random stall/flush soak against a reference queue model: order preserved and out_* stable whenever out_valid && !out_ready.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: shared constants and operand-bundle type for the ID/EX boundary
//   REG_PC           architectural PC register address (r15)
//   PC_OFFSET        value added to the instruction address when r15 is read
//   CTRL_W           width of the opaque decoded-control bundle
//   operand_bundle_t {a, b, rd, wb, ctrl} as seen by the execute stage
package id_ex_operand_stage_pkg;
  localparam logic [3:0] REG_PC = 4'hF;
  localparam logic [31:0] PC_OFFSET = 32'd8;
  localparam int CTRL_W = 16;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] rd;
    logic wb;
    logic [CTRL_W-1:0] ctrl;
  } operand_bundle_t;
endpackage

// File: rtl/id_ex_operand_stage_operand_fwd_mux.sv
// operand_fwd_mux: priority operand selector (PC read, EX forward, WB forward, register file)
//   addr     register address of this operand
//   pc_val   instruction address already offset for an r15 read
//   ex_*     EX-stage forwarding source
//   wb_*     WB-stage forwarding source
//   rf_data  register-file read-port value
//   operand  resolved value
module operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [3:0]  addr,
  input  logic [31:0] pc_val,
  input  logic        ex_en,
  input  logic [3:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] rf_data,
  output logic [31:0] operand
);
  // r15 is checked first so a pipeline write to r15 is never forwarded.
  assign operand = addr == REG_PC ? pc_val :
                   ex_en && ex_rd == addr ? ex_data :
                   wb_en && wb_rd == addr ? wb_data : rf_data;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: resolves and registers operands for execute behind a valid/ready skid buffer
//   Clk, Clr                     clock, synchronous active-low reset
//   in_valid/in_ready            decode handshake (in_ready is registered)
//   in_rn/in_rm/in_rd/in_wb      operand sources, destination and write enable
//   in_ctrl, in_pc               control pass-through, instruction address
//   rf_a/rf_b                    register-file read ports for in_rn/in_rm
//   ex_fwd_*/wb_fwd_*            forwarding sources, EX has priority over WB
//   flush                        kills everything held in the stage
//   out_valid/out_ready          execute handshake
//   out_a/out_b/out_rd/out_wb/out_ctrl  registered operand bundle
module id_ex_operand_stage #(
  parameter int CTRL_W = id_ex_operand_stage_pkg::CTRL_W,
  parameter logic [31:0] PC_OFFSET = id_ex_operand_stage_pkg::PC_OFFSET
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [3:0]        in_rd,
  input  logic              in_wb,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       rf_a,
  input  logic [31:0]       rf_b,
  input  logic              ex_fwd_en,
  input  logic [3:0]        ex_fwd_rd,
  input  logic [31:0]       ex_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [3:0]        wb_fwd_rd,
  input  logic [31:0]       wb_fwd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_a,
  output logic [31:0]       out_b,
  output logic [3:0]        out_rd,
  output logic              out_wb,
  output logic [CTRL_W-1:0] out_ctrl
);
  localparam int W = 69 + CTRL_W;
  logic [31:0] pc_val, op_a, op_b;
  logic [W-1:0] in_d, out_q, skid_q;
  logic skid_valid, accept;
  assign pc_val = in_pc + PC_OFFSET;
  operand_fwd_mux u_mux_a (
    .addr(in_rn), .pc_val(pc_val),
    .ex_en(ex_fwd_en), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .rf_data(rf_a), .operand(op_a)
  );
  operand_fwd_mux u_mux_b (
    .addr(in_rm), .pc_val(pc_val),
    .ex_en(ex_fwd_en), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .rf_data(rf_b), .operand(op_b)
  );
  assign in_d = {op_a, op_b, in_rd, in_wb, in_ctrl};
  assign in_ready = ~skid_valid;
  assign accept = in_valid && in_ready;
  assign {out_a, out_b, out_rd, out_wb, out_ctrl} = out_q;
  // Skid only fills while OUT is stalled, so skid_valid implies out_valid and
  // an accept never coincides with a pending skid entry.
  always_ff @(posedge Clk)
    if (!Clr) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid || accept;
      skid_valid <= 1'b0;
      if (skid_valid) out_q <= skid_q;
      else if (accept) out_q <= in_d;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q <= in_d;
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: scoreboard bench for the ID/EX operand stage
module tb_id_ex_operand_stage;
  localparam int BW = 85;
  logic Clk = 1'b0;
  logic Clr = 1'b0;
  logic in_valid = 1'b0, in_wb = 1'b0, ex_fwd_en = 1'b0, wb_fwd_en = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_wb;
  logic [3:0] in_rn = '0, in_rm = '0, in_rd = '0, ex_fwd_rd = '0, wb_fwd_rd = '0, out_rd;
  logic [15:0] in_ctrl = '0, out_ctrl;
  logic [31:0] in_pc = '0, rf_a = '0, rf_b = '0, ex_fwd_data = '0, wb_fwd_data = '0, out_a, out_b;
  logic [BW-1:0] exp_q[$];
  int checks = 0, passed = 0;
  always #5 Clk = ~Clk;
  id_ex_operand_stage dut (
    .Clk(Clk), .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_wb(in_wb), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .rf_a(rf_a), .rf_b(rf_b),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wb(out_wb), .out_ctrl(out_ctrl)
  );
  function automatic void check(string name, logic [BW:0] act, logic [BW:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction
  function automatic logic [31:0] resolve(logic [3:0] a, logic [31:0] rf);
    if (a == 4'hF) return in_pc + 32'd8;
    if (ex_fwd_en && ex_fwd_rd == a) return ex_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == a) return wb_fwd_data;
    return rf;
  endfunction
  // Reference model: the stage is an in-order queue that flush/reset empties.
  task automatic cyc();
    logic acc;
    logic [BW-1:0] b;
    acc = Clr && !flush && in_valid && in_ready;
    b = {resolve(in_rn, rf_a), resolve(in_rm, rf_b), in_rd, in_wb, in_ctrl};
    @(posedge Clk);
    if (!Clr || flush) exp_q.delete();
    else if (acc) exp_q.push_back(b);
    #1;
  endtask
  task automatic set_in(logic v, logic [3:0] rn, logic [3:0] rm, logic [31:0] a, logic [31:0] b);
    in_valid = v; in_rn = rn; in_rm = rm; rf_a = a; rf_b = b;
    in_rd = $urandom_range(0, 14); in_wb = 1'($urandom); in_ctrl = 16'($urandom);
  endtask
  logic hold = 1'b0;
  logic [BW-1:0] prev;
  always @(negedge Clk) begin
    logic [BW-1:0] cur;
    cur = {out_a, out_b, out_rd, out_wb, out_ctrl};
    if (Clr) begin
      if (hold) check("hold_stable", {out_valid, cur}, {1'b1, prev});
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", {1'b1, cur}, {1'b0, cur});
        else begin
          check("bundle", {1'b1, cur}, {1'b1, exp_q[0]});
          if (out_ready && !flush) void'(exp_q.pop_front());
        end
      end
    end
    hold = Clr && out_valid && !out_ready && !flush;
    prev = cur;
  end
  initial begin
    logic [31:0] first_a;
    cyc(); cyc();
    Clr = 1'b1;
    check("reset_out_valid", {85'd0, out_valid}, 86'd0);
    check("reset_in_ready", {85'd0, in_ready}, 86'd1);
    check("reset_out_a", {54'd0, out_a}, 86'd0);
    check("reset_out_ctrl", {70'd0, out_ctrl}, 86'd0);
    set_in(1, 4'd3, 4'd1, 32'h0000B0B0, 32'h11); in_pc = 32'h0000_0800;
    cyc();
    check("plain_valid", {85'd0, out_valid}, 86'd1);
    check("plain_a", {54'd0, out_a}, {54'd0, 32'h0000B0B0});
    set_in(1, 4'd2, 4'hF, 32'h5, 32'h6); in_pc = 32'h00001000;
    cyc();
    check("pc_b", {54'd0, out_b}, {54'd0, 32'h00001008});
    set_in(1, 4'd5, 4'd5, 32'h1, 32'h2);
    ex_fwd_en = 1; ex_fwd_rd = 5; ex_fwd_data = 32'hAAAA0000;
    wb_fwd_en = 1; wb_fwd_rd = 5; wb_fwd_data = 32'h0000BBBB;
    cyc();
    check("ex_wins_a", {54'd0, out_a}, {54'd0, 32'hAAAA0000});
    check("ex_wins_b", {54'd0, out_b}, {54'd0, 32'hAAAA0000});
    ex_fwd_en = 0;
    cyc();
    check("wb_fwd_a", {54'd0, out_a}, {54'd0, 32'h0000BBBB});
    set_in(1, 4'hF, 4'd0, 32'h7, 32'h8); ex_fwd_en = 1; ex_fwd_rd = 4'hF; in_pc = 32'h2000;
    cyc();
    check("r15_no_fwd", {54'd0, out_a}, {54'd0, 32'h2008});
    ex_fwd_en = 0; wb_fwd_en = 0;
    set_in(0, 0, 0, 0, 0);
    cyc();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 4'(i), 4'(i + 1), 32'hC000 + 32'(i), 32'hD000 + 32'(i));
      cyc();
      if (i == 1) check("full2_in_ready", {85'd0, in_ready}, 86'd0);
    end
    check("bp_head", {54'd0, out_a}, {54'd0, 32'hC000});
    set_in(0, 0, 0, 0, 0); out_ready = 1;
    for (int i = 0; i < 3; i++) cyc();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 4'(i + 6), 4'(i + 8), $urandom, $urandom);
      cyc();
    end
    set_in(1, 4'd1, 4'd2, 32'hDEAD, 32'hBEEF); flush = 1;
    cyc();
    flush = 0; set_in(0, 0, 0, 0, 0);
    check("flush_out_valid", {85'd0, out_valid}, 86'd0);
    check("flush_in_ready", {85'd0, in_ready}, 86'd1);
    out_ready = 1;
    cyc();
    check("flush_stays_empty", {85'd0, out_valid}, 86'd0);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4'(i), 4'(i), $urandom, $urandom); out_ready = 1'($urandom);
      cyc();
    end
    Clr = 0; set_in(1, 4'd4, 4'd4, 32'h4444, 32'h4444);
    cyc(); cyc();
    Clr = 1; set_in(0, 0, 0, 0, 0);
    check("midreset_out_valid", {85'd0, out_valid}, 86'd0);
    check("midreset_in_ready", {85'd0, in_ready}, 86'd1);
    check("midreset_out_a", {54'd0, out_a}, 86'd0);
    cyc();
    check("midreset_discard", {85'd0, out_valid}, 86'd0);
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      in_pc = $urandom & 32'hFFFF_FFFC;
      ex_fwd_en = 1'($urandom); ex_fwd_rd = 4'($urandom_range(0, 15)); ex_fwd_data = $urandom;
      wb_fwd_en = 1'($urandom); wb_fwd_rd = 4'($urandom_range(0, 15)); wb_fwd_data = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      Clr = ($urandom_range(0, 199) != 0);
      cyc();
    end
    flush = 0; Clr = 1; out_ready = 1; set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc();
    check("drained_valid", {85'd0, out_valid}, 86'd0);
    check("drained_queue", 86'(exp_q.size()), 86'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
